// File: rtl/fadder_serial_n.sv
// Digit-serial adder/subtractor: adds DIGIT bits per clock, LSB digit first,
// with a registered carry between digits and a start/busy/done handshake.
module fadder_serial_n #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             SUB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             OVF
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a, op_b, acc, acc_next;
    logic             carry;
    logic [DIGIT:0]   dsum;
    logic             load, step, last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    // The current digit always sits in the low bits of the operand shift registers.
    assign dsum     = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    assign acc_next = (acc >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
            S     <= '0;
            Cout  <= 1'b0;
            OVF   <= 1'b0;
        end else begin
            done <= last;
            if (load) begin
                op_a  <= A;
                op_b  <= SUB ? ~B : B;
                carry <= SUB ? 1'b1 : Cin;
                cnt   <= '0;
            end else if (step) begin
                op_a  <= op_a >> DIGIT;
                op_b  <= op_b >> DIGIT;
                acc   <= acc_next;
                carry <= dsum[DIGIT];
                cnt   <= cnt + CW'(1);
            end
            // On the final digit the operand MSBs are still at bit DIGIT-1.
            if (last) begin
                S    <= acc_next;
                Cout <= dsum[DIGIT];
                OVF  <= (op_a[DIGIT-1] == op_b[DIGIT-1]) && (dsum[DIGIT-1] != op_a[DIGIT-1]);
            end
        end
    end

endmodule

// File: tb/tb_fadder_serial_n.sv
// Bench for fadder_serial_n: three instances (DIGIT=4, 1, 16) checked against
// an arithmetic reference model with directed, handshake, reset and random tests.
module tb_fadder_serial_n;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a_in = '0, b_in = '0;
    logic        cin_in = 1'b0, sub_in = 1'b0;
    logic        start_i [3];
    logic        busy_o  [3];
    logic        done_o  [3];
    logic [15:0] s_o     [3];
    logic        cout_o  [3];
    logic        ovf_o   [3];

    int lat [3] = '{4, 16, 1};
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fadder_serial_n #(.WIDTH(16), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_i[0]), .A(a_in), .B(b_in), .Cin(cin_in),
        .SUB(sub_in), .busy(busy_o[0]), .done(done_o[0]), .S(s_o[0]), .Cout(cout_o[0]), .OVF(ovf_o[0]));
    fadder_serial_n #(.WIDTH(16), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_i[1]), .A(a_in), .B(b_in), .Cin(cin_in),
        .SUB(sub_in), .busy(busy_o[1]), .done(done_o[1]), .S(s_o[1]), .Cout(cout_o[1]), .OVF(ovf_o[1]));
    fadder_serial_n #(.WIDTH(16), .DIGIT(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start_i[2]), .A(a_in), .B(b_in), .Cin(cin_in),
        .SUB(sub_in), .busy(busy_o[2]), .done(done_o[2]), .S(s_o[2]), .Cout(cout_o[2]), .OVF(ovf_o[2]));

    // Reference: plain integer arithmetic; returns {ovf, cout, s}.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        longint usum;
        int     ssum;
        logic   ov;
        if (sub) begin
            usum = longint'(a) + longint'(16'hFFFF ^ b) + 1;
            ssum = int'($signed(a)) - int'($signed(b));
        end else begin
            usum = longint'(a) + longint'(b) + longint'(cin);
            ssum = int'($signed(a)) + int'($signed(b)) + int'(cin);
        end
        ov = (ssum > 32767) || (ssum < -32768);
        return {ov, usum[16], usum[15:0]};
    endfunction

    // Starts one operation now and waits (bounded) for done; cyc counts clocks after the start edge.
    task automatic do_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, output int cyc, output int bcnt);
        a_in = a; b_in = b; cin_in = cin; sub_in = sub;
        start_i[idx] = 1'b1;
        @(negedge clk);
        start_i[idx] = 1'b0;
        cyc = 0;
        bcnt = 0;
        while (!done_o[idx] && cyc < 64) begin
            if (busy_o[idx]) bcnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        #2;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({busy_o[i], done_o[i], s_o[i], cout_o[i], ovf_o[i]} !== 20'h0) begin
                n_fail++;
                $display("[TB] FAIL reset inst%0d: busy=%b done=%b S=%h Cout=%b OVF=%b, want all 0",
                         i, busy_o[i], done_o[i], s_o[i], cout_o[i], ovf_o[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [15:0] va [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
        logic [15:0] vb [5] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
        logic        vc [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [17:0] ve [5] = '{{2'b00, 16'h2234}, {2'b01, 16'h0000}, {2'b10, 16'h8000},
                                {2'b00, 16'hFFFE}, {2'b11, 16'h7FFF}};
        int cyc, bcnt;
        for (int t = 0; t < 5; t++) begin
            do_op(0, va[t], vb[t], vc[t], vs[t], cyc, bcnt);
            n_checks++;
            if ({ovf_o[0], cout_o[0], s_o[0]} !== ve[t]) begin
                n_fail++;
                $display("[TB] FAIL directed%0d result: got S=%h Cout=%b OVF=%b, want %h", t,
                         s_o[0], cout_o[0], ovf_o[0], ve[t]);
            end
            n_checks++;
            if (cyc != 4 || bcnt != 4) begin
                n_fail++;
                $display("[TB] FAIL directed%0d timing: done after %0d busy %0d, want 4/4", t, cyc, bcnt);
            end
        end
    endtask

    task automatic test_ignore_while_busy();
        int cyc;
        a_in = 16'h1111; b_in = 16'h2222; cin_in = 1'b0; sub_in = 1'b0;
        start_i[0] = 1'b1;
        @(negedge clk);
        start_i[0] = 1'b0;
        @(negedge clk);
        a_in = 16'h7000; b_in = 16'h0123; cin_in = 1'b1; sub_in = 1'b1;
        start_i[0] = 1'b1;
        @(negedge clk);
        start_i[0] = 1'b0;
        cyc = 2;
        while (!done_o[0] && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (s_o[0] !== 16'h3333 || cyc != 4) begin
            n_fail++;
            $display("[TB] FAIL ignore_busy: got S=%h at cycle %0d, want 3333 at 4", s_o[0], cyc);
        end
        @(negedge clk);
        n_checks++;
        if (busy_o[0] !== 1'b0 || done_o[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ignore_busy_queue: busy=%b done=%b, want 0/0", busy_o[0], done_o[0]);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bcnt;
        do_op(0, 16'h4000, 16'h0100, 1'b0, 1'b0, cyc, bcnt);
        a_in = 16'h0001; b_in = 16'h0002; cin_in = 1'b0; sub_in = 1'b0;
        start_i[0] = 1'b1;
        @(negedge clk);
        start_i[0] = 1'b0;
        n_checks++;
        if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b1 || s_o[0] !== 16'h4100) begin
            n_fail++;
            $display("[TB] FAIL b2b_accept: done=%b busy=%b S=%h, want 0/1/4100", done_o[0], busy_o[0], s_o[0]);
        end
        cyc = 0;
        while (!done_o[0] && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (s_o[0] !== 16'h0003 || cyc != 4) begin
            n_fail++;
            $display("[TB] FAIL b2b_result: got S=%h after %0d, want 0003 after 4", s_o[0], cyc);
        end
    endtask

    task automatic test_reset_abort();
        int cyc, bcnt;
        a_in = 16'h1234; b_in = 16'h1111; cin_in = 1'b0; sub_in = 1'b0;
        start_i[0] = 1'b1;
        @(negedge clk);
        start_i[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy_o[0] !== 1'b0 || done_o[0] !== 1'b0 || s_o[0] !== 16'h0 || cout_o[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort: busy=%b done=%b S=%h Cout=%b, want 0/0/0000/0",
                     busy_o[0], done_o[0], s_o[0], cout_o[0]);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (done_o[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_no_done: done=%b, want 0", done_o[0]);
        end
        rst_n = 1'b1;
        @(negedge clk);
        do_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, cyc, bcnt);
        n_checks++;
        if (s_o[0] !== 16'h0100 || cyc != 4) begin
            n_fail++;
            $display("[TB] FAIL after_abort: got S=%h after %0d, want 0100 after 4", s_o[0], cyc);
        end
    endtask

    task automatic test_random(input int idx, input int count);
        logic [15:0] ra, rb;
        logic        rc, rs;
        logic [17:0] exp;
        int cyc, bcnt;
        for (int t = 0; t < count; t++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            if (t == 0) begin ra = 16'h8000; rb = 16'h8000; rs = 1'b0; end
            exp = model(ra, rb, rc, rs);
            do_op(idx, ra, rb, rc, rs, cyc, bcnt);
            n_checks++;
            if ({ovf_o[idx], cout_o[idx], s_o[idx]} !== exp) begin
                n_fail++;
                $display("[TB] FAIL random inst%0d A=%h B=%h Cin=%b SUB=%b: got S=%h Cout=%b OVF=%b, want %h",
                         idx, ra, rb, rc, rs, s_o[idx], cout_o[idx], ovf_o[idx], exp);
            end
            n_checks++;
            if (cyc != lat[idx] || bcnt != lat[idx]) begin
                n_fail++;
                $display("[TB] FAIL random_timing inst%0d: done after %0d busy %0d, want %0d",
                         idx, cyc, bcnt, lat[idx]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) start_i[i] = 1'b0;
        test_reset();
        test_directed();
        test_ignore_while_busy();
        test_back_to_back();
        test_reset_abort();
        test_random(0, 1000);
        test_random(1, 1000);
        test_random(2, 1000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fadder_serial_n.md
Name: fadder_serial_n

Overview:
- Multi-cycle, digit-serial adder/subtractor; generalises the single-bit full adder to WIDTH-bit operands.
- Processes DIGIT bits per clock, least-significant digit first, with a registered carry between digits.
- Uses a start/busy/done handshake.
- Datapath building block for the lab ALU where area matters more than latency; shares its carry semantics with the 1-bit full adder (S = A^B^C, Cout = majority).

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits added per clock; 1 <= DIGIT <= WIDTH.
N (localparam), WIDTH/DIGIT, number of digit cycles per operation.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when not busy
A  input  WIDTH  operand A; sampled with start
B  input  WIDTH  operand B; sampled with start
Cin  input  1  carry-in; sampled with start; ignored when SUB=1
SUB  input  1  0: S = A+B+Cin; 1: S = A-B (A + ~B + 1); sampled with start
busy  output  1  operation in progress
done  output  1  one-cycle pulse: S/Cout/OVF just updated
S  output  WIDTH  registered result
Cout  output  1  carry out of MSB (SUB=1: 1 = no borrow)
OVF  output  1  two's-complement signed overflow

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; busy=0, done=0, S=0, Cout=0, OVF=0; internal operand/shift registers and carry cleared.
- States:
  - IDLE: waiting for start.
  - RUN: digit counter 0..N-1.
  - No separate DONE state; done is a registered pulse.
- IDLE, start=1 at edge E0:
  - Latch A into opA.
  - Latch opB = SUB ? ~B : B.
  - Latch carry = SUB ? 1 : Cin.
  - Clear digit counter; go to RUN.
  - busy=1 from E0.
- RUN, each edge Ek (k=1..N):
  - Add opA[DIGIT-1:0] + opB[DIGIT-1:0] + carry.
  - Shift the DIGIT-bit sum into the MSB end of the result shift register.
  - Shift opA/opB right by DIGIT.
  - Register the digit carry-out.
- At edge EN:
  - S <= full result.
  - Cout <= final carry.
  - OVF <= (opA_msb == opB_msb) && (S_msb != opA_msb), using the effective (possibly inverted) B.
  - done=1 for exactly the cycle after EN; busy=0 in that same cycle; return to IDLE.
- Latency: start edge to done-high is N cycles; busy is high for exactly N cycles.
- S/Cout/OVF change only at completion and hold until the next completion or reset. Partial sums are never visible on S.
- start while busy=1: ignored, no effect on the current operation. The operation is not queued.
- start while done=1: accepted (state is IDLE), giving back-to-back operation with no bubble. done falls next cycle; busy rises.
- Operand inputs may change freely after the start edge.
- rst_n asserted mid-operation: aborts immediately to reset values; no done pulse. Next start behaves normally.
- N=1 (DIGIT=WIDTH): single RUN cycle; done one cycle after start.
- DIGIT=1: fully bit-serial; N=WIDTH cycles.
- Arithmetic is modulo 2^WIDTH; no saturation.

Test Plan:
- WIDTH=16, DIGIT=4: A=0x1234, B=0x0FFF, Cin=1, SUB=0 -> S=0x2234, Cout=0, OVF=0; done exactly 4 cycles after start edge; busy high 4 cycles.
- Full carry ripple across digits: A=0xFFFF, B=0x0001, Cin=0 -> S=0x0000, Cout=1, OVF=0. Signed overflow: A=0x7FFF, B=0x0001 -> S=0x8000, Cout=0, OVF=1.
- Subtract: A=0x0005, B=0x0007, SUB=1, Cin=1 (ignored) -> S=0xFFFE, Cout=0, OVF=0. Subtract overflow: A=0x8000, B=0x0001, SUB=1 -> S=0x7FFF, Cout=1, OVF=1.
- Handshake:
  - Pulse start again at cycle 2 of busy with different operands -> ignored; first result unchanged.
  - Assert start in the done cycle (A=0x0001, B=0x0002) -> accepted; S=0x0003 with done 4 cycles later.
- Reset abort: deassert rst_n during the 2nd RUN cycle -> busy=0, done=0, S=0 immediately (async). After release, A=0x00FF + B=0x0001 -> S=0x0100.
- Parameter sweep: DIGIT=1 (done after 16 cycles) and DIGIT=16 (done after 1 cycle). 1000 random A/B/Cin/SUB each -> S/Cout/OVF match the behavioural model.
